// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and sizes for the register-file port controller.
//   state_t   - controller mode (CLEAR while zeroing the file, RUN afterwards)
//   REG_COUNT - number of architectural registers
//   ADDR_W    - register index width
//   DATA_W    - register data width
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;

endpackage

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: combinational grant logic for the shared register-file
// write port, plus the debug starvation counter.
//   clk, rst_n            - clock, synchronous active-low reset
//   run                   - controller is in RUN (no grants otherwise)
//   wb_valid/addr/data    - writeback write request
//   dbg_valid/write/addr/wdata - debug request (only writes compete here)
//   wb_grant, dbg_grant   - winner of this cycle
//   we, wr, wdata         - write-port drive for the winner
module rf_write_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT     = 4,
  parameter bit ZERO_REG_PROTECT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              dbg_valid,
  input  logic              dbg_write,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              wb_grant,
  output logic              dbg_grant,
  output logic              we,
  output logic [ADDR_W-1:0] wr,
  output logic [DATA_W-1:0] wdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          dbg_wr_req;
  logic          force_dbg;

  assign dbg_wr_req = dbg_valid & dbg_write;
  assign force_dbg  = (starve_cnt == SW'(STARVE_LIMIT));

  // Writeback has priority unless the debug write has lost STARVE_LIMIT times
  // in a row; then writeback is held off for one cycle.
  assign dbg_grant = run & dbg_wr_req & (~wb_valid | force_dbg);
  assign wb_grant  = run & wb_valid & ~dbg_grant;

  // A write to register 0 is still handshaken but never reaches the file.
  always_comb begin
    we    = 1'b0;
    wr    = '0;
    wdata = '0;
    if (dbg_grant) begin
      wr    = dbg_addr;
      wdata = dbg_wdata;
      we    = ~(ZERO_REG_PROTECT && (dbg_addr == '0));
    end else if (wb_grant) begin
      wr    = wb_addr;
      wdata = wb_data;
      we    = ~(ZERO_REG_PROTECT && (wb_addr == '0));
    end
  end

  // Debug reads leave the counter untouched; only a losing write advances it.
  always_ff @(posedge clk) begin
    if (!rst_n || !run || !dbg_valid || dbg_grant) begin
      starve_cnt <= '0;
    end else if (dbg_wr_req && !force_dbg) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: owns the write port and read port 3 of the 32x32
// register file. Zeroes every register after reset, then arbitrates the write
// port between writeback and the debug requester and serves debug reads.
//   clk, rst_n                      - clock, synchronous active-low reset
//   wb_valid/addr/data, wb_ready    - writeback write handshake
//   dbg_valid/write/addr/wdata,
//   dbg_ready                       - debug request handshake
//   dbg_rvalid, dbg_rdata           - debug read return, one cycle after accept
//   busy                            - clear sequence in progress
//   rf_we, rf_wr, rf_wdata          - register file write port
//   rf_r3, rf_rdata3                - register file read port 3
module regfile_port_ctrl
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT     = 4,
  parameter bit ZERO_REG_PROTECT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              dbg_valid,
  input  logic              dbg_write,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W-1:0] rf_r3,
  input  logic [DATA_W-1:0] rf_rdata3
);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              run;
  logic              rd_fire;
  logic              wb_grant;
  logic              dbg_grant;
  logic              arb_we;
  logic [ADDR_W-1:0] arb_wr;
  logic [DATA_W-1:0] arb_wdata;
  logic              vld_p1;
  logic [DATA_W-1:0] rdata_p1;

  assign run  = (state == RUN);
  assign busy = ~run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == ADDR_W'(REG_COUNT - 1)) begin
        state <= RUN;
      end
    end
  end

  rf_write_arbiter #(
    .STARVE_LIMIT     (STARVE_LIMIT),
    .ZERO_REG_PROTECT (ZERO_REG_PROTECT)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .dbg_valid (dbg_valid),
    .dbg_write (dbg_write),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .wb_grant  (wb_grant),
    .dbg_grant (dbg_grant),
    .we        (arb_we),
    .wr        (arb_wr),
    .wdata     (arb_wdata)
  );

  // While clearing, the write port belongs to the clear counter.
  always_comb begin
    if (run) begin
      rf_we    = arb_we;
      rf_wr    = arb_wr;
      rf_wdata = arb_wdata;
    end else begin
      rf_we    = 1'b1;
      rf_wr    = clr_cnt;
      rf_wdata = '0;
    end
  end

  assign wb_ready = wb_grant;

  // Reads never need the write port; a debug write is ready only when granted.
  assign dbg_ready = run & (~(dbg_valid & dbg_write) | dbg_grant);
  assign rd_fire   = run & dbg_valid & ~dbg_write;
  assign rf_r3     = rd_fire ? dbg_addr : '0;

  // ---- stage p1: read return ----
  // rf_rdata3 is sampled before any same-edge write commits, so a colliding
  // read sees the old contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= rd_fire;
      if (rd_fire) begin
        rdata_p1 <= rf_rdata3;
      end
    end
  end

  assign dbg_rvalid = vld_p1;
  assign dbg_rdata  = rdata_p1;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
module tb_regfile_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        dbg_valid;
  logic        dbg_write;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ready;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        busy;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_r3;
  logic [31:0] rf_rdata3;

  logic [31:0] mem [32];
  logic        init_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_port_ctrl #(
    .STARVE_LIMIT     (4),
    .ZERO_REG_PROTECT (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready),
    .dbg_valid  (dbg_valid),
    .dbg_write  (dbg_write),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_ready  (dbg_ready),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .busy       (busy),
    .rf_we      (rf_we),
    .rf_wr      (rf_wr),
    .rf_wdata   (rf_wdata),
    .rf_r3      (rf_r3),
    .rf_rdata3  (rf_rdata3)
  );

  // Register file model: garbage until the bench arms it, then write on edge,
  // combinational read.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hBAD0_0000 | 32'(i);
    end else if (rf_we) begin
      mem[rf_wr] <= rf_wdata;
    end
  end
  assign rf_rdata3 = mem[rf_r3];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    dbg_valid = 1'b0; dbg_write = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    init_done = 1'b1;
    #1;
    // reset state
    check_eq("rst_busy",   32'(busy), 32'd1);
    check_eq("rst_we",     32'(rf_we), 32'd1);
    check_eq("rst_wr",     32'(rf_wr), 32'd0);
    check_eq("rst_wbrdy",  32'(wb_ready), 32'd0);
    check_eq("rst_dbgrdy", 32'(dbg_ready), 32'd0);
    check_eq("rst_rvalid", 32'(dbg_rvalid), 32'd0);
    check_eq("rst_rdata",  dbg_rdata, 32'd0);
    rst_n = 1'b1;

    // clear sequence: registers 0..31, writeback offered in the last cycle
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0033;
      end
      #1;
      check_eq("clr_we",    32'(rf_we), 32'd1);
      check_eq("clr_wr",    32'(rf_wr), 32'(i));
      check_eq("clr_wdata", rf_wdata, 32'd0);
      check_eq("clr_busy",  32'(busy), 32'd1);
      check_eq("clr_wbrdy", 32'(wb_ready), 32'd0);
      step();
    end
    #1;
    check_eq("run_busy",   32'(busy), 32'd0);
    check_eq("run_wbrdy",  32'(wb_ready), 32'd1);
    check_eq("run_wr",     32'(rf_wr), 32'd3);
    check_eq("run_wdata",  rf_wdata, 32'h0000_0033);
    check_eq("run_dbgrdy", 32'(dbg_ready), 32'd1);
    check_eq("clr_mem31",  mem[31], 32'd0);
    check_eq("clr_mem17",  mem[17], 32'd0);
    step();

    // writeback beats a simultaneous debug write
    wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    dbg_valid = 1'b1; dbg_write = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'h1234_5678;
    #1;
    check_eq("prio_wbrdy",  32'(wb_ready), 32'd1);
    check_eq("prio_dbgrdy", 32'(dbg_ready), 32'd0);
    check_eq("prio_wr",     32'(rf_wr), 32'd5);
    check_eq("prio_wdata",  rf_wdata, 32'hDEAD_BEEF);
    step();
    wb_valid = 1'b0;
    #1;
    check_eq("dbgw_rdy",   32'(dbg_ready), 32'd1);
    check_eq("dbgw_we",    32'(rf_we), 32'd1);
    check_eq("dbgw_wdata", rf_wdata, 32'h1234_5678);
    step();
    dbg_valid = 1'b0;
    #1;
    check_eq("dbgw_mem5", mem[5], 32'h1234_5678);
    check_eq("idle_we",   32'(rf_we), 32'd0);
    check_eq("idle_wr",   32'(rf_wr), 32'd0);
    check_eq("idle_wdat", rf_wdata, 32'd0);
    check_eq("idle_r3",   32'(rf_r3), 32'd0);
    step();

    // anti-starvation: debug write forced on the 5th contested cycle
    wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h0000_00A0;
    dbg_valid = 1'b1; dbg_write = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h0000_0099;
    for (int k = 1; k <= 5; k++) begin
      #1;
      if (k < 5) begin
        check_eq("starve_wbrdy",  32'(wb_ready), 32'd1);
        check_eq("starve_dbgrdy", 32'(dbg_ready), 32'd0);
      end else begin
        check_eq("force_wbrdy",  32'(wb_ready), 32'd0);
        check_eq("force_dbgrdy", 32'(dbg_ready), 32'd1);
        check_eq("force_wr",     32'(rf_wr), 32'd9);
        check_eq("force_wdata",  rf_wdata, 32'h0000_0099);
      end
      step();
    end
    #1;
    // counter restarted: the debug write loses again
    check_eq("restart_wbrdy",  32'(wb_ready), 32'd1);
    check_eq("restart_dbgrdy", 32'(dbg_ready), 32'd0);
    step();
    wb_valid = 1'b0; dbg_valid = 1'b0;
    #1;
    check_eq("force_mem9", mem[9], 32'h0000_0099);
    step();

    // read/write collision returns the old value, then the new one
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5_A5A5;
    dbg_valid = 1'b1; dbg_write = 1'b0; dbg_addr = 5'd7;
    #1;
    check_eq("hz_r3",     32'(rf_r3), 32'd7);
    check_eq("hz_dbgrdy", 32'(dbg_ready), 32'd1);
    check_eq("hz_wbrdy",  32'(wb_ready), 32'd1);
    check_eq("hz_rvalid0", 32'(dbg_rvalid), 32'd0);
    step();
    wb_valid = 1'b0;
    #1;
    check_eq("hz_rvalid1", 32'(dbg_rvalid), 32'd1);
    check_eq("hz_old",     dbg_rdata, 32'd0);
    step();
    dbg_valid = 1'b0;
    #1;
    check_eq("hz_rvalid2", 32'(dbg_rvalid), 32'd1);
    check_eq("hz_new",     dbg_rdata, 32'hA5A5_A5A5);
    step();
    #1;
    check_eq("hz_rvalid3", 32'(dbg_rvalid), 32'd0);
    step();

    // writes to register 0 are acknowledged but dropped
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    check_eq("z_wbrdy", 32'(wb_ready), 32'd1);
    check_eq("z_we",    32'(rf_we), 32'd0);
    step();
    wb_valid = 1'b0;
    dbg_valid = 1'b1; dbg_write = 1'b0; dbg_addr = 5'd0;
    step();
    dbg_valid = 1'b0;
    #1;
    check_eq("z_rvalid", 32'(dbg_rvalid), 32'd1);
    check_eq("z_rdata",  dbg_rdata, 32'd0);
    step();

    // one-cycle reset in RUN with a read in flight
    dbg_valid = 1'b1; dbg_write = 1'b0; dbg_addr = 5'd5;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; dbg_valid = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h0000_0044;
    for (int i = 0; i < 32; i++) begin
      #1;
      check_eq("rr_rvalid", 32'(dbg_rvalid), 32'd0);
      check_eq("rr_wbrdy",  32'(wb_ready), 32'd0);
      check_eq("rr_wr",     32'(rf_wr), 32'(i));
      check_eq("rr_busy",   32'(busy), 32'd1);
      step();
    end
    #1;
    check_eq("rr_run_busy",  32'(busy), 32'd0);
    check_eq("rr_run_wbrdy", 32'(wb_ready), 32'd1);
    check_eq("rr_run_wr",    32'(rf_wr), 32'd4);
    step();
    wb_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_port_ctrl.md
# regfile_port_ctrl

Controller that owns the single write port and the third read port of the 32×32 register file. It zeroes all 32 registers after reset. It then shares the write port between the core writeback stage and a debug/loader requester, using fixed writeback priority with an anti-starvation override. It also services debug register reads through read port 3. It sits between the pipeline writeback logic, the debug UART bridge and the register file.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive cycles a pending debug write may lose arbitration before it is forced through.
- ZERO_REG_PROTECT, 1: when 1, writes to register 0 are acknowledged but never reach the file.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wb_valid  in  1  writeback request.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- wb_ready  out  1  writeback accepted this cycle.
- dbg_valid  in  1  debug request.
- dbg_write  in  1  1 = write, 0 = read.
- dbg_addr  in  5  debug register index.
- dbg_wdata  in  32  debug write data.
- dbg_ready  out  1  debug request accepted this cycle.
- dbg_rvalid  out  1  one-cycle pulse; dbg_rdata is valid.
- dbg_rdata  out  32  debug read result.
- busy  out  1  high while the clear sequence runs.
- rf_we  out  1  register file write enable.
- rf_wr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- rf_r3  out  5  register file read port 3 address.
- rf_rdata3  in  32  register file read port 3 data (combinational from rf_r3).

## Operation
- Two states: CLEAR and RUN. Reset enters CLEAR with clr_cnt = 0.
- CLEAR:
  - Each cycle drives rf_we = 1, rf_wr = clr_cnt, rf_wdata = 0, then increments clr_cnt.
  - After writing register 31 (clr_cnt wraps 31 → 0), the next state is RUN.
  - busy = 1; wb_ready = 0; dbg_ready = 0.
- RUN, write arbitration (combinational, Mealy):
  - Debug reads never use the write port, so a read can be accepted in the same cycle as any write.
  - Writeback wins by default.
  - Debug write wins only when wb_valid = 0, or when starve_cnt == STARVE_LIMIT.
  - When the debug write is forced, wb_ready = 0 and writeback holds its request.
- starve_cnt:
  - Increments when a debug write is pending and loses.
  - Clears when the debug write is granted or when dbg_valid = 0.
  - Saturates at STARVE_LIMIT.
- Granted write: rf_we = 1 and rf_wr/rf_wdata are taken from the winner.
  - If ZERO_REG_PROTECT is set and the address is 0, rf_we = 0 but the ready signal is still asserted.
- Debug read:
  - dbg_ready = 1 whenever in RUN; rf_r3 = dbg_addr.
  - rf_rdata3 is registered into dbg_rdata; dbg_rvalid pulses the next cycle.
- Read/write hazard: a debug read and a granted write to the same address in the same cycle return the old value (read before write).
- Outputs when not granted: rf_we = 0; rf_wr/rf_wdata/rf_r3 = 0 when idle.
- Reset mid-operation (rst_n low in any state):
  - Aborts the current activity and restarts CLEAR from register 0.
  - A pending dbg_rvalid is dropped.
- Reset values: busy = 1, rf_we = 1 (clear of register 0 begins on the first cycle after reset release), wb_ready = 0, dbg_ready = 0, dbg_rvalid = 0, dbg_rdata = 0, starve_cnt = 0.

## Timing
- The clear sequence takes exactly 32 cycles; RUN begins on the 33rd cycle after rst_n rises.
- Write latency is 0 cycles to grant. The register file commits at the same rising edge at which the handshake completes.
- Read latency is 1 cycle: dbg_rvalid is asserted on the cycle after dbg_valid && !dbg_write && dbg_ready.
- A writeback that arrives in the last CLEAR cycle is not accepted; it is accepted in the first RUN cycle.
- Back-to-back debug reads are sustained at one per cycle.

## Structure
- Shared package regfile_pkg holds:
  - the state enum {CLEAR, RUN};
  - REG_COUNT = 32, ADDR_W = 5, DATA_W = 32.
- One natural sub-module, rf_write_arbiter. It is purely combinational grant logic plus starve_cnt. The top level holds the FSM, the clear counter and the read-return register.

## Test plan
- Reset release, then idle: rf_we = 1 with rf_wr = 0..31 and rf_wdata = 0 for 32 cycles; busy falls on cycle 33.
- RUN, wb_valid = 1 with addr 5 / data 0xDEADBEEF, plus debug write to addr 5 / 0x12345678 → wb is granted; the debug write waits.
- wb_valid held high continuously with a debug write pending → debug is granted on the 5th cycle, with wb_ready = 0 in that cycle; starve_cnt returns to 0.
- Debug read addr 7 while wb writes 0xA5A5A5A5 to addr 7 → dbg_rvalid the next cycle with the old value; a second read returns 0xA5A5A5A5.
- Writeback to addr 0 with 0xFFFFFFFF and ZERO_REG_PROTECT = 1 → wb_ready = 1, rf_we = 0; a debug read of addr 0 returns 0.
- rst_n asserted for one cycle while in RUN → the clear sequence restarts at register 0; dbg_rvalid is suppressed; wb_ready = 0 for 32 cycles.
